// File: rtl/alu_sequencer.sv
// alu_sequencer: request/response front end for the 32-bit ALU.
// Takes one operation at a time and drives the ALU with stable operands.
// Single-cycle and MUL ops get a fixed EXEC/CAPTURE sequence. DIV is
// started with a one-cycle pulse and then watched by a watchdog.
// The ALU outputs are captured into a response register, which is held
// until the requester takes it.
module alu_sequencer #(
    parameter int N           = 32,
    parameter int OP_W        = 4,
    parameter int FLAGS_W     = 5,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic               CLK,
    input  logic               rst,

    // request channel
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [OP_W-1:0]    req_op,
    input  logic [N-1:0]       req_a,
    input  logic [N-1:0]       req_b,
    input  logic               req_uns,

    // response channel
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [N-1:0]       rsp_result,
    output logic [N-1:0]       rsp_high,
    output logic [FLAGS_W-1:0] rsp_flags,
    output logic               rsp_err,

    // ALU side
    output logic [N-1:0]       alu_a,
    output logic [N-1:0]       alu_b,
    output logic [OP_W-1:0]    alu_opcode,
    output logic               alu_uns,
    output logic               alu_start,
    input  logic [N-1:0]       alu_result,
    input  logic [N-1:0]       alu_high,
    input  logic [FLAGS_W-1:0] alu_flags,
    input  logic               alu_finished
);

    // Sequencer states. Plain constants keep the encoding fixed for
    // older tools and for anyone probing the state register.
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] EXEC     = 3'd1;
    localparam logic [2:0] DIV_WAIT = 3'd2;
    localparam logic [2:0] CAPTURE  = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    // Opcodes. Only the ends of the legal range and DIV matter here.
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
    localparam logic [OP_W-1:0] OP_DIV = OP_W'(4);
    localparam logic [OP_W-1:0] OP_NEG = OP_W'(11);

    // The watchdog counts DIV_WAIT cycles. It is cleared in EXEC, so during
    // the k-th DIV_WAIT cycle it holds k-1. The last allowed cycle is
    // therefore the one where the count equals DIV_TIMEOUT-1.
    localparam int              CNT_W    = $clog2(DIV_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

    logic [2:0]       state;
    logic [2:0]       state_nx;

    // Operation latched at the handshake. The ALU sees only these values.
    logic [OP_W-1:0]  op_q;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic             uns_q;

    logic [CNT_W-1:0] wd_cnt;

    logic             accept;
    logic             req_legal;
    logic             alu_drive;
    logic             div_done;
    logic             div_timeout;

    // Opcodes 1..11 are implemented. 0 and 12..15 are rejected before
    // the ALU is ever driven.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_NEG);
    endfunction

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign accept    = req_valid && req_ready;
    assign req_legal = op_legal(req_op);

    // The ALU is driven only while an operation is in flight. Elsewhere
    // opcode 0 makes the ALU hold.
    assign alu_drive  = (state == EXEC) || (state == DIV_WAIT) || (state == CAPTURE);
    assign alu_a      = alu_drive ? a_q   : '0;
    assign alu_b      = alu_drive ? b_q   : '0;
    assign alu_opcode = alu_drive ? op_q  : '0;
    assign alu_uns    = alu_drive ? uns_q : 1'b0;

    // The start pulse is decoded from state, so an async reset drops it
    // at once without waiting for a clock edge.
    assign alu_start = (state == EXEC) && (op_q == OP_DIV);

    // In the first DIV_WAIT cycle, alu_finished may still be left over
    // from an earlier operation. It is trusted only once the counter has
    // moved past zero.
    assign div_done    = (state == DIV_WAIT) && (wd_cnt != '0) && alu_finished;
    assign div_timeout = (state == DIV_WAIT) && !div_done && (wd_cnt == CNT_LAST);

    // Next-state decode for the operation sequence.
    always_comb begin
        // NOTE: default first so every path assigns state_nx; otherwise a latch is inferred.
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = req_legal ? EXEC : DONE;
                end
            end
            EXEC: begin
                state_nx = (op_q == OP_DIV) ? DIV_WAIT : CAPTURE;
            end
            DIV_WAIT: begin
                if (div_done) begin
                    state_nx = CAPTURE;
                end else if (div_timeout) begin
                    state_nx = DONE;
                end
            end
            CAPTURE: begin
                state_nx = DONE;
            end
            DONE: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            // NOTE: non-blocking assignments for all clocked state, so every register samples pre-edge values.
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Latch the accepted operation. It then stays fixed until the next handshake.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            uns_q <= 1'b0;
        end else if (accept) begin
            op_q  <= req_op;
            a_q   <= req_a;
            b_q   <= req_b;
            uns_q <= req_uns;
        end
    end

    // Division watchdog: cleared in EXEC, incremented in every DIV_WAIT cycle.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (state == EXEC) begin
            wd_cnt <= '0;
        end else if (state == DIV_WAIT) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Response register. It is loaded by CAPTURE, or by an error path
    // (illegal op, DIV timeout), and holds its value until the next load.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            rsp_result <= '0;
            rsp_high   <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else if ((accept && !req_legal) || div_timeout) begin
            rsp_result <= '0;
            rsp_high   <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b1;
        end else if (state == CAPTURE) begin
            rsp_result <= alu_result;
            rsp_high   <= alu_high;
            rsp_flags  <= alu_flags;
            rsp_err    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed test for alu_sequencer.
// Includes a small behavioural ALU with a controllable finished line.
module tb_alu_sequencer;

    logic        CLK;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_uns;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [31:0] rsp_high;
    logic [4:0]  rsp_flags;
    logic        rsp_err;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_opcode;
    logic        alu_uns;
    logic        alu_start;
    logic [31:0] alu_result;
    logic [31:0] alu_high;
    logic [4:0]  alu_flags;
    logic        alu_finished;

    int n_checks;
    int n_fail;

    alu_sequencer #(
        .N(32), .OP_W(4), .FLAGS_W(5), .DIV_TIMEOUT(64)
    ) dut (
        .CLK(CLK), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_uns(req_uns),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_high(rsp_high), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_uns(alu_uns),
        .alu_start(alu_start), .alu_result(alu_result), .alu_high(alu_high),
        .alu_flags(alu_flags), .alu_finished(alu_finished)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- behavioural ALU ----------------
    logic        m_carry;
    logic        m_ovf;
    logic [63:0] m_prod;

    // Combinational result and flags. Flag order is {GE, POS, OVF, CARRY, ZERO}.
    always_comb begin
        alu_result = '0;
        alu_high   = '0;
        m_carry    = 1'b0;
        m_ovf      = 1'b0;
        m_prod     = {32'b0, alu_a} * {32'b0, alu_b};
        case (alu_opcode)
            4'd1: begin
                {m_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
                m_ovf = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            4'd2: begin
                alu_result = alu_a - alu_b;
                m_carry    = alu_a < alu_b;
                m_ovf      = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            4'd3: {alu_high, alu_result} = m_prod;
            4'd4: begin
                if (alu_b != 0) begin
                    alu_result = alu_a / alu_b;
                    alu_high   = alu_a % alu_b;
                end
            end
            4'd5:  alu_result = alu_a & alu_b;
            4'd6:  alu_result = alu_a | alu_b;
            4'd7:  alu_result = alu_a ^ alu_b;
            4'd8:  alu_result = ~alu_a;
            4'd9:  alu_result = alu_a << alu_b[4:0];
            4'd10: alu_result = alu_a >> alu_b[4:0];
            4'd11: alu_result = -alu_a;
            default: alu_result = '0;
        endcase
        alu_flags[4] = alu_uns ? (alu_a >= alu_b) : ($signed(alu_a) >= $signed(alu_b));
        alu_flags[3] = !alu_result[31] && (alu_result != 0);
        alu_flags[2] = m_ovf;
        alu_flags[1] = m_carry;
        alu_flags[0] = (alu_result == 0);
    end

    // finished: set by MUL and left set (so it is stale afterwards).
    // For DIV it is set one edge after start. force_nofin masks it.
    logic [1:0] m_busy;
    logic       m_fin;
    logic       force_nofin;
    always @(posedge CLK or negedge rst) begin
        if (!rst) begin
            m_busy <= 2'd0;
            m_fin  <= 1'b0;
        end else if (alu_start) begin
            m_busy <= 2'd1;
        end else if (m_busy != 2'd0) begin
            m_busy <= m_busy - 2'd1;
            m_fin  <= (m_busy == 2'd1);
        end else if (alu_opcode == 4'd3) begin
            m_fin <= 1'b1;
        end
    end
    assign alu_finished = m_fin && !force_nofin;

    // Free-running count of cycles with alu_start high.
    int start_total;
    always @(posedge CLK or negedge rst) begin
        if (!rst) start_total <= 0;
        else if (alu_start) start_total <= start_total + 1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic uns);
        check("req_ready_before_issue", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_uns   = uns;
        tick();
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_uns   = 1'b0;
    endtask

    // Count edges after the handshake until rsp_valid is seen, up to 200.
    task automatic wait_rsp(output int cycles);
        cycles = 0;
        while (!rsp_valid && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    int cyc;
    int start_snap;

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b0;
        req_valid   = 1'b0;
        req_op      = '0;
        req_a       = '0;
        req_b       = '0;
        req_uns     = 1'b0;
        rsp_ready   = 1'b1;
        force_nofin = 1'b0;

        // reset state
        #2;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_high", rsp_high, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_alu_opcode", alu_opcode, 0);
        check("rst_alu_start", alu_start, 0);
        check("rst_alu_a", alu_a, 0);
        tick();
        rst = 1'b1;
        tick();

        // ADD 5+7
        issue(4'd1, 32'd5, 32'd7, 1'b0);
        check("add_exec_opcode", alu_opcode, 4'd1);
        check("add_exec_a", alu_a, 32'd5);
        check("add_exec_start", alu_start, 0);
        wait_rsp(cyc);
        check("add_latency", cyc, 2);
        check("add_result", rsp_result, 32'd12);
        check("add_flags", rsp_flags, 5'b01000);
        check("add_err", rsp_err, 0);
        tick();
        check("add_req_ready_back", req_ready, 1);
        check("add_rsp_valid_drop", rsp_valid, 0);

        // SUB 3-3 then MUL 0x10000*0x10000, back to back
        issue(4'd2, 32'd3, 32'd3, 1'b0);
        wait_rsp(cyc);
        check("sub_latency", cyc, 2);
        check("sub_result", rsp_result, 32'd0);
        check("sub_flags", rsp_flags, 5'b10001);
        tick();
        issue(4'd3, 32'h0001_0000, 32'h0001_0000, 1'b1);
        wait_rsp(cyc);
        check("mul_latency", cyc, 2);
        check("mul_result", rsp_result, 32'd0);
        check("mul_high", rsp_high, 32'd1);
        check("mul_err", rsp_err, 0);
        tick();

        // DIV 100/7 while alu_finished is still stale at 1 from the MUL
        check("div_stale_fin_present", alu_finished, 1);
        start_snap = start_total;
        issue(4'd4, 32'd100, 32'd7, 1'b1);
        check("div_exec_start", alu_start, 1);
        check("div_exec_opcode", alu_opcode, 4'd4);
        tick();
        check("div_wait_start_low", alu_start, 0);
        check("div_wait_b_stable", alu_b, 32'd7);
        check("div_wait1_no_rsp", rsp_valid, 0);
        cyc = 1;
        while (!rsp_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        check("div_latency", cyc, 4);
        check("div_result", rsp_result, 32'd14);
        check("div_high", rsp_high, 32'd2);
        check("div_flags", rsp_flags, 5'b11000);
        check("div_err", rsp_err, 0);
        check("div_start_pulses", start_total - start_snap, 1);
        tick();

        // DIV timeout
        force_nofin = 1'b1;
        issue(4'd4, 32'd9, 32'd3, 1'b0);
        wait_rsp(cyc);
        check("div_timeout_latency", cyc, 65);
        check("div_timeout_err", rsp_err, 1);
        check("div_timeout_result", rsp_result, 0);
        check("div_timeout_high", rsp_high, 0);
        check("div_timeout_flags", rsp_flags, 0);
        tick();
        force_nofin = 1'b0;

        // illegal op 13, then hold the response for 10 cycles
        rsp_ready = 1'b0;
        issue(4'd13, 32'd1, 32'd2, 1'b0);
        check("illegal_rsp_valid", rsp_valid, 1);
        check("illegal_err", rsp_err, 1);
        check("illegal_result", rsp_result, 0);
        check("illegal_flags", rsp_flags, 0);
        check("illegal_alu_opcode", alu_opcode, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("illegal_hold_valid", rsp_valid, 1);
            check("illegal_hold_req_ready", req_ready, 0);
            check("illegal_hold_err", rsp_err, 1);
        end
        rsp_ready = 1'b1;
        tick();
        check("illegal_release", req_ready, 1);

        // ADD 2+3 leaves a nonzero value in the response register
        issue(4'd1, 32'd2, 32'd3, 1'b0);
        wait_rsp(cyc);
        check("add2_result", rsp_result, 32'd5);
        tick();

        // reset in the middle of DIV_WAIT
        force_nofin = 1'b1;
        issue(4'd4, 32'd50, 32'd5, 1'b0);
        tick();
        tick();
        check("mid_div_busy", req_ready, 0);
        check("mid_div_opcode", alu_opcode, 4'd4);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_req_ready", req_ready, 1);
        check("async_rst_rsp_valid", rsp_valid, 0);
        check("async_rst_rsp_result", rsp_result, 0);
        check("async_rst_alu_opcode", alu_opcode, 0);
        check("async_rst_alu_a", alu_a, 0);
        check("async_rst_alu_start", alu_start, 0);
        tick();
        rst = 1'b1;
        force_nofin = 1'b0;
        tick();
        check("post_rst_no_rsp", rsp_valid, 0);

        // ADD 1+1 after the reset
        issue(4'd1, 32'd1, 32'd1, 1'b0);
        wait_rsp(cyc);
        check("post_rst_add_latency", cyc, 2);
        check("post_rst_add_result", rsp_result, 32'd2);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
